// File: rtl/cfg_pkg.sv
// System-level configuration shared by all stack pipeline blocks.
package cfg_pkg;
    localparam int unsigned ENGS_N = 4;
endpackage

// File: rtl/stk_pkg.sv
// Stack pipeline types: opcodes, response status, engine-client FSM states and command layout.
package stk_pkg;
    localparam int unsigned DAT_W = 128;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_INV  = 2'd2
    } opcode_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_EMPTY   = 2'd1,
        STATUS_FULL    = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } client_state_t;

    typedef struct packed {
        opcode_t           opcode;
        logic [DAT_W-1:0]  dat;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(opcode_t) + DAT_W;

    function automatic cmd_t make_cmd(input opcode_t opcode, input logic [DAT_W-1:0] dat);
        cmd_t c;
        c.opcode = opcode;
        c.dat    = dat;
        return c;
    endfunction
endpackage

// File: rtl/stk_eng_client_q.sv
// Generic DEPTH-entry FIFO with registered full/empty flags; push is ignored when full, pop when empty.
module stk_eng_client_q #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        cnt_nxt = cnt;
        if (do_push && !do_pop) begin
            cnt_nxt = cnt + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Flags come from the next count so they are plain flops, not decode of the pointers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == (AW+1)'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/stk_eng_client.sv
// Engine-side initiator for one stack pipeline lane: queues host commands, issues them, returns results.
// Optional response watchdog enabled by defining STK_ENG_CLIENT_TIMEOUT_EN.
module stk_eng_client
    import stk_pkg::*;
#(
    parameter int unsigned ENG_ID = 0,
    parameter int unsigned ENGS_N = cfg_pkg::ENGS_N,
    parameter int unsigned CMDQ_N = 4,
    parameter int unsigned TMO_W  = 10
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              i_host_vld,
    input  opcode_t           i_host_opcode,
    input  logic [127:0]      i_host_dat,
    output logic              o_host_rdy,
    output logic              o_cmd_vld,
    output opcode_t           o_cmd_opcode,
    output logic [127:0]      o_cmd_dat,
    input  logic              i_cmd_ack,
    input  logic [ENGS_N-1:0] i_rsp_vld,
    input  logic [127:0]      i_rsp_dat,
    input  status_t           i_rsp_status,
    output logic              o_res_vld,
    output logic [127:0]      o_res_dat,
    output status_t           o_res_status,
    input  logic              i_res_rdy,
    output logic              o_busy
);
    localparam logic [ENGS_N-1:0] ENG_MASK = ENGS_N'(1) << ENG_ID;

    if (ENG_ID >= ENGS_N || CMDQ_N < 2 || (CMDQ_N & (CMDQ_N - 1)) != 0 || TMO_W < 1) begin : g_cfg_err
        $error("stk_eng_client: illegal parameter combination");
    end

    client_state_t state;
    client_state_t state_nxt;
    cmd_t          q_head;
    logic          q_full;
    logic          q_empty;
    logic          q_pop;
    logic          rsp_own;
    logic          rsp_take;
    logic          late_pending;
    logic          tmo_hit;
    logic          load_cmd;
    logic          capture;

    stk_eng_client_q #(
        .W     (CMD_W),
        .DEPTH (CMDQ_N)
    ) u_q (
        .clk      (clk),
        .arst     (arst),
        .push     (i_host_vld),
        .push_dat (make_cmd(i_host_opcode, i_host_dat)),
        .pop      (q_pop),
        .full     (q_full),
        .empty    (q_empty),
        .head     (q_head)
    );

    assign o_host_rdy = !q_full;
    assign rsp_own    = |(i_rsp_vld & ENG_MASK);
    assign rsp_take   = rsp_own && !late_pending;
    assign q_pop      = (state == ISSUE) && i_cmd_ack;
    assign capture    = rsp_take && ((state == WAIT) || ((state == ISSUE) && i_cmd_ack));
    assign load_cmd   = (state_nxt == ISSUE) && (state != ISSUE);

`ifdef STK_ENG_CLIENT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    // The count is armed on WAIT entry; the decrement that would reach zero is the timeout.
    assign tmo_hit = (state == WAIT) && !rsp_take && (tmo_cnt == TMO_W'(1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tmo_cnt      <= '0;
            late_pending <= 1'b0;
        end else begin
            if ((state == ISSUE) && i_cmd_ack && !rsp_take) begin
                tmo_cnt <= '1;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (tmo_hit) begin
                late_pending <= 1'b1;
            end else if (rsp_own) begin
                late_pending <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit      = 1'b0;
    assign late_pending = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!q_empty && !late_pending) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (i_cmd_ack) state_nxt = rsp_take ? RESP : WAIT;
            end
            WAIT: begin
                if (rsp_take || tmo_hit) state_nxt = RESP;
            end
            RESP: begin
                if (i_res_rdy) state_nxt = (!q_empty && !late_pending) ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_cmd_vld = (state == ISSUE);
        o_res_vld = (state == RESP);
        o_busy    = !q_empty || (state != IDLE);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_cmd_opcode <= OP_PUSH;
            o_cmd_dat    <= '0;
            o_res_dat    <= '0;
            o_res_status <= STATUS_OK;
        end else begin
            if (load_cmd) begin
                o_cmd_opcode <= q_head.opcode;
                o_cmd_dat    <= q_head.dat;
            end
            if (capture) begin
                o_res_dat    <= i_rsp_dat;
                o_res_status <= i_rsp_status;
            end else if (tmo_hit) begin
                o_res_dat    <= '0;
                o_res_status <= STATUS_TIMEOUT;
            end
        end
    end

    a_rsp_own_legal: assert property (@(posedge clk) disable iff (arst)
        rsp_own |-> ((state == WAIT) || ((state == ISSUE) && i_cmd_ack) || late_pending));
endmodule

// File: tb/tb_stk_eng_client.sv
// Self-checking bench for stk_eng_client: directed scenarios plus a randomized run against a queue model.
module tb_stk_eng_client;
    import stk_pkg::*;

    localparam int unsigned ENG_ID = 1;
    localparam int unsigned ENGS_N = 4;
    localparam logic [3:0]  OWN    = 4'b0010;

    logic          clk = 1'b0;
    logic          arst;
    logic          i_host_vld;
    opcode_t       i_host_opcode;
    logic [127:0]  i_host_dat;
    logic          o_host_rdy;
    logic          o_cmd_vld;
    opcode_t       o_cmd_opcode;
    logic [127:0]  o_cmd_dat;
    logic          i_cmd_ack;
    logic [3:0]    i_rsp_vld;
    logic [127:0]  i_rsp_dat;
    status_t       i_rsp_status;
    logic          o_res_vld;
    logic [127:0]  o_res_dat;
    status_t       o_res_status;
    logic          i_res_rdy;
    logic          o_busy;

    int checks = 0;
    int errors = 0;

    stk_eng_client #(
        .ENG_ID (ENG_ID),
        .ENGS_N (ENGS_N),
        .CMDQ_N (4),
        .TMO_W  (4)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .i_host_vld    (i_host_vld),
        .i_host_opcode (i_host_opcode),
        .i_host_dat    (i_host_dat),
        .o_host_rdy    (o_host_rdy),
        .o_cmd_vld     (o_cmd_vld),
        .o_cmd_opcode  (o_cmd_opcode),
        .o_cmd_dat     (o_cmd_dat),
        .i_cmd_ack     (i_cmd_ack),
        .i_rsp_vld     (i_rsp_vld),
        .i_rsp_dat     (i_rsp_dat),
        .i_rsp_status  (i_rsp_status),
        .o_res_vld     (o_res_vld),
        .o_res_dat     (o_res_dat),
        .o_res_status  (o_res_status),
        .i_res_rdy     (i_res_rdy),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_cmd(input opcode_t op, input logic [127:0] dat);
        check("push_rdy", o_host_rdy, 1'b1);
        i_host_vld    = 1'b1;
        i_host_opcode = op;
        i_host_dat    = dat;
        step();
        i_host_vld = 1'b0;
    endtask

    task automatic wait_cmd(input string tag);
        int n = 0;
        while (!o_cmd_vld && n < 20) begin
            step();
            n++;
        end
        check(tag, o_cmd_vld, 1'b1);
    endtask

    task automatic respond(input logic [127:0] dat, input status_t st);
        i_rsp_vld    = OWN;
        i_rsp_dat    = dat;
        i_rsp_status = st;
        step();
        i_rsp_vld = '0;
    endtask

    task automatic consume();
        i_res_rdy = 1'b1;
        step();
        i_res_rdy = 1'b0;
    endtask

    task automatic serve_one(input string tag, input opcode_t op, input logic [127:0] dat);
        logic [127:0] rd;
        status_t      rs;
        rd = rnd128();
        rs = status_t'($urandom_range(0, 2));
        wait_cmd({tag, "_vld"});
        check({tag, "_op"}, o_cmd_opcode, op);
        check({tag, "_dat"}, o_cmd_dat, dat);
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        respond(rd, rs);
        check({tag, "_res_vld"}, o_res_vld, 1'b1);
        check({tag, "_res_dat"}, o_res_dat, rd);
        check({tag, "_res_st"}, o_res_status, rs);
        consume();
    endtask

    cmd_t         exp_cmd[$];
    logic [127:0] exp_rdat;
    status_t      exp_rst;

    initial begin
        logic [127:0] a5;
        logic [127:0] d;
        logic [127:0] p0;
        logic [127:0] p1;
        int           n;

        arst = 1'b1;
        i_host_vld = 1'b0; i_host_opcode = OP_PUSH; i_host_dat = '0;
        i_cmd_ack = 1'b0; i_rsp_vld = '0; i_rsp_dat = '0; i_rsp_status = STATUS_OK;
        i_res_rdy = 1'b0;
        step(); step(); step();
        arst = 1'b0;
        step();
        check("rst_host_rdy", o_host_rdy, 1'b1);
        check("rst_cmd_vld", o_cmd_vld, 1'b0);
        check("rst_res_vld", o_res_vld, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_cmd_dat", o_cmd_dat, '0);
        check("rst_res_dat", o_res_dat, '0);

        // Basic transaction and issue latency
        a5 = {16{8'hA5}};
        d  = rnd128();
        push_cmd(OP_PUSH, a5);
        check("lat_n1_vld", o_cmd_vld, 1'b0);
        check("lat_n1_busy", o_busy, 1'b1);
        step();
        check("lat_n2_vld", o_cmd_vld, 1'b1);
        check("lat_n2_op", o_cmd_opcode, OP_PUSH);
        check("lat_n2_dat", o_cmd_dat, a5);
        step();
        check("hold_vld", o_cmd_vld, 1'b1);
        check("hold_dat", o_cmd_dat, a5);
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        check("wait_cmd_vld", o_cmd_vld, 1'b0);
        check("wait_res_vld", o_res_vld, 1'b0);
        respond(d, STATUS_OK);
        check("t1_res_vld", o_res_vld, 1'b1);
        check("t1_res_dat", o_res_dat, d);
        check("t1_res_st", o_res_status, STATUS_OK);
        consume();
        check("t1_res_done", o_res_vld, 1'b0);
        check("t1_busy", o_busy, 1'b0);

        // Fill the queue while the pipe withholds ack
        p0 = rnd128();
        p1 = rnd128();
        i_host_vld = 1'b1;
        i_host_opcode = OP_PUSH; i_host_dat = p0; step();
        i_host_opcode = OP_PUSH; i_host_dat = p1; step();
        i_host_opcode = OP_POP;  i_host_dat = '0; step();
        i_host_opcode = OP_INV;  i_host_dat = '0; step();
        i_host_vld = 1'b0;
        check("full_rdy", o_host_rdy, 1'b0);
        i_host_vld = 1'b1; i_host_opcode = OP_PUSH; i_host_dat = rnd128();
        step();
        i_host_vld = 1'b0;
        check("full_rdy_hold", o_host_rdy, 1'b0);
        check("full_head_op", o_cmd_opcode, OP_PUSH);
        check("full_head_dat", o_cmd_dat, p0);
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        check("unfull_rdy", o_host_rdy, 1'b1);
        d = rnd128();
        respond(d, STATUS_OK);
        check("full_res_dat", o_res_dat, d);
        consume();
        serve_one("ord1", OP_PUSH, p1);
        serve_one("ord2", OP_POP, '0);
        serve_one("ord3", OP_INV, '0);
        check("full_drop_busy", o_busy, 1'b0);

        // Foreign-lane response must be ignored
        p0 = rnd128();
        push_cmd(OP_PUSH, p0);
        wait_cmd("lane_vld");
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        i_rsp_vld = 4'b0001; i_rsp_dat = rnd128(); i_rsp_status = STATUS_FULL;
        step();
        i_rsp_vld = '0;
        step(); step();
        check("lane_res_vld", o_res_vld, 1'b0);
        check("lane_busy", o_busy, 1'b1);
        check("lane_cmd_vld", o_cmd_vld, 1'b0);
        d = rnd128();
        respond(d, STATUS_EMPTY);
        check("lane_own_dat", o_res_dat, d);
        check("lane_own_st", o_res_status, STATUS_EMPTY);
        consume();

        // Result backpressure, then back-to-back issue
        push_cmd(OP_POP, '0);
        push_cmd(OP_INV, '0);
        wait_cmd("bp_vld");
        check("bp_op", o_cmd_opcode, OP_POP);
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        respond(128'h1234, STATUS_OK);
        for (int i = 0; i < 5; i++) begin
            check("bp_res_vld", o_res_vld, 1'b1);
            check("bp_res_dat", o_res_dat, 128'h1234);
            step();
        end
        consume();
        check("bp_next_vld", o_cmd_vld, 1'b1);
        check("bp_next_op", o_cmd_opcode, OP_INV);
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        d = rnd128();
        respond(d, STATUS_OK);
        check("bp_next_res", o_res_dat, d);
        consume();

        // Reset while waiting; the response is dropped
        push_cmd(OP_PUSH, rnd128());
        wait_cmd("rst_w_vld");
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        arst = 1'b1;
        i_rsp_vld = OWN; i_rsp_dat = rnd128(); i_rsp_status = STATUS_FULL;
        step();
        check("rstw_cmd_vld", o_cmd_vld, 1'b0);
        check("rstw_res_vld", o_res_vld, 1'b0);
        check("rstw_res_dat", o_res_dat, '0);
        check("rstw_cmd_dat", o_cmd_dat, '0);
        i_rsp_vld = '0;
        arst = 1'b0;
        step(); step();
        check("rstw_res_vld2", o_res_vld, 1'b0);
        check("rstw_busy", o_busy, 1'b0);
        check("rstw_rdy", o_host_rdy, 1'b1);

`ifdef STK_ENG_CLIENT_TIMEOUT_EN
        // Watchdog expiry, late response discarded, next command normal
        push_cmd(OP_POP, '0);
        wait_cmd("tmo_vld");
        i_cmd_ack = 1'b1;
        step();
        i_cmd_ack = 1'b0;
        n = 0;
        while (!o_res_vld && n < 40) begin
            n++;
            step();
        end
        check("tmo_wait_cycles", n, 15);
        check("tmo_status", o_res_status, STATUS_TIMEOUT);
        check("tmo_dat", o_res_dat, '0);
        consume();
        p0 = rnd128();
        push_cmd(OP_PUSH, p0);
        step(); step(); step();
        check("tmo_blocked", o_cmd_vld, 1'b0);
        check("tmo_busy", o_busy, 1'b1);
        respond(rnd128(), STATUS_FULL);
        check("tmo_late_res", o_res_vld, 1'b0);
        serve_one("tmo_next", OP_PUSH, p0);
`endif

        // Randomized run against the queue model
        begin
            int  sent = 0;
            int  done = 0;
            int  wcnt = 0;
            logic outstanding = 1'b0;
            logic have_res = 1'b0;
            localparam int N_TXN = 60;
            exp_cmd.delete();
            n = 0;
            while (done < N_TXN && n < 5000) begin
                i_rsp_vld = 4'($urandom) & ~OWN;
                i_rsp_dat = rnd128();
                i_rsp_status = status_t'($urandom_range(0, 3));
                if (o_res_vld) begin
                    if (have_res) begin
                        check("rand_res_dat", o_res_dat, exp_rdat);
                        check("rand_res_st", o_res_status, exp_rst);
                    end else begin
                        check("rand_res_unexp", 1'b1, 1'b0);
                    end
                    i_res_rdy = $urandom_range(0, 1) == 1;
                    if (i_res_rdy) begin
                        have_res = 1'b0;
                        done++;
                    end
                end
                if (o_cmd_vld) begin
                    if (exp_cmd.size() == 0) begin
                        check("rand_cmd_unexp", 1'b1, 1'b0);
                    end else begin
                        check("rand_cmd_op", o_cmd_opcode, exp_cmd[0].opcode);
                        check("rand_cmd_dat", o_cmd_dat, exp_cmd[0].dat);
                    end
                    i_cmd_ack = $urandom_range(0, 2) == 0;
                    if (i_cmd_ack) begin
                        if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
                        if ($urandom_range(0, 3) == 0) begin
                            i_rsp_vld = i_rsp_vld | OWN;
                            i_rsp_status = status_t'($urandom_range(0, 2));
                            exp_rdat = i_rsp_dat;
                            exp_rst  = i_rsp_status;
                            have_res = 1'b1;
                        end else begin
                            outstanding = 1'b1;
                            wcnt = 0;
                        end
                    end
                end else if (outstanding) begin
                    wcnt++;
                    if ($urandom_range(0, 1) == 1 || wcnt > 8) begin
                        i_rsp_vld = i_rsp_vld | OWN;
                        i_rsp_status = status_t'($urandom_range(0, 2));
                        exp_rdat = i_rsp_dat;
                        exp_rst  = i_rsp_status;
                        have_res = 1'b1;
                        outstanding = 1'b0;
                    end
                end
                if (sent < N_TXN && o_host_rdy && $urandom_range(0, 1) == 1) begin
                    i_host_vld    = 1'b1;
                    i_host_opcode = opcode_t'($urandom_range(0, 2));
                    i_host_dat    = rnd128();
                    exp_cmd.push_back(make_cmd(i_host_opcode, i_host_dat));
                    sent++;
                end
                step();
                i_host_vld = 1'b0;
                i_cmd_ack  = 1'b0;
                i_rsp_vld  = '0;
                i_res_rdy  = 1'b0;
                n++;
            end
            check("rand_done", done, N_TXN);
            check("rand_q_empty", exp_cmd.size(), 0);
            check("rand_busy", o_busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
